// File: rtl/pixel_color_sched.sv
// Purpose : round-robin scheduler that feeds per-pixel iteration counts to an external
//           colormap and queues the returned colours with their framebuffer addresses.
// Latency : grant -> colormap (CM_LAT cycles) -> FIFO push; out_valid one cycle after push.
// Backpr. : grants are credit-limited (fifo_count + inflight < FIFO_DEPTH), never gated by out_ready.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         per-requester handshake (at most one ready bit per cycle)
//   req_iter/req_addr           packed per-requester iteration count and pixel address
//   cm_iter_count/cm_max_iter/cm_valid_in   lookup request to the colormap
//   cm_rgb565/cm_valid_out      colormap result, CM_LAT cycles after cm_valid_in
//   out_valid/out_ready/out_rgb565/out_addr coloured pixel stream (FIFO head)
//   cfg_max_iter/cfg_we/cfg_busy           max_iter update; busy while draining lookups
module pixel_color_sched #(
  parameter int N_REQ        = 4,
  parameter int ITER_W       = 16,
  parameter int ADDR_W       = 17,
  parameter int FIFO_DEPTH   = 4,
  parameter int CM_LAT       = 1,
  parameter int DEF_MAX_ITER = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ITER_W-1:0]   req_iter,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  output logic [ITER_W-1:0]         cm_iter_count,
  output logic [ITER_W-1:0]         cm_max_iter,
  output logic                      cm_valid_in,
  input  logic [15:0]               cm_rgb565,
  input  logic                      cm_valid_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               out_rgb565,
  output logic [ADDR_W-1:0]         out_addr,
  input  logic [ITER_W-1:0]         cfg_max_iter,
  input  logic                      cfg_we,
  output logic                      cfg_busy
);

  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int FPTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W  = $clog2(CM_LAT + 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    rr_ptr;
  logic [INF_W-1:0]    inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic [FPTR_W-1:0]   wr_ptr, rd_ptr;
  logic [ITER_W-1:0]   max_iter, pend_max_iter;
  logic                pend_ld, max_ld;

  logic [15:0]         fifo_rgb  [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];

  logic [ADDR_W-1:0]   dly_addr [CM_LAT];
  logic [CM_LAT-1:0]   dly_vld;

  logic                gnt_found;
  logic [PTR_W-1:0]    gnt_idx;
  logic [31:0]         occ;
  logic                credit_ok;
  logic                grant;
  logic [ADDR_W-1:0]   gnt_addr;
  logic                ret;
  logic                push, pop;

  // ---------------------------------------------------------------------------
  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    int j;
    j         = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!gnt_found && req_valid[PTR_W'(j)]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(j);
      end
    end
  end

  // Lookups in flight will land in the FIFO unconditionally, so they are
  // reserved against its capacity before a new grant is allowed.
  assign occ       = 32'(fifo_count) + 32'(inflight);
  assign credit_ok = (occ < 32'(FIFO_DEPTH));

  // rst_n gates the grant so nothing is accepted while reset is held.
  assign grant     = rst_n && (state == ST_RUN) && credit_ok && gnt_found;
  assign gnt_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];

  assign req_ready     = grant ? (N_REQ'(1) << gnt_idx) : '0;
  assign cm_valid_in   = grant;
  assign cm_iter_count = grant ? req_iter[int'(gnt_idx)*ITER_W +: ITER_W] : '0;
  assign cm_max_iter   = max_iter;

  // ---------------------------------------------------------------------------
  // Address delay line, aligned with the colormap return. The valid bit lets a
  // stray cm_valid_out (e.g. a lookup issued before a reset) be ignored.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_vld <= '0;
      for (int k = 0; k < CM_LAT; k++) dly_addr[k] <= '0;
    end else begin
      dly_vld[0]  <= grant;
      dly_addr[0] <= gnt_addr;
      for (int k = 1; k < CM_LAT; k++) begin
        dly_vld[k]  <= dly_vld[k-1];
        dly_addr[k] <= dly_addr[k-1];
      end
    end
  end

  assign ret  = dly_vld[CM_LAT-1];
  assign push = cm_valid_out && ret;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({grant, ret})
        2'b10:   inflight <= inflight + INF_W'(1);
        2'b01:   inflight <= inflight - INF_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO. Credit accounting guarantees a push never meets a full FIFO.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rgb[wr_ptr]  <= cm_rgb565;
      fifo_addr[wr_ptr] <= dly_addr[CM_LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == FPTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr + FPTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == FPTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr + FPTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign out_valid  = (fifo_count != '0);
  assign out_rgb565 = fifo_rgb[rd_ptr];
  assign out_addr   = fifo_addr[rd_ptr];

  // ---------------------------------------------------------------------------
  // Arbitration pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Config FSM: stop issuing, wait for outstanding lookups to return, then swap
  // max_iter. The FIFO keeps draining meanwhile; its contents are already coloured.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    pend_ld   = 1'b0;
    max_ld    = 1'b0;
    case (state)
      ST_RUN: begin
        if (cfg_we) begin
          state_nxt = ST_DRAIN;
          pend_ld   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cfg_we) begin
          pend_ld = 1'b1;
        end else if (inflight == '0) begin
          state_nxt = ST_RUN;
          max_ld    = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RUN;
      pend_max_iter <= ITER_W'(DEF_MAX_ITER);
      max_iter      <= ITER_W'(DEF_MAX_ITER);
    end else begin
      state <= state_nxt;
      if (pend_ld) pend_max_iter <= cfg_max_iter;
      if (max_ld)  max_iter      <= pend_max_iter;
    end
  end

  assign cfg_busy = (state == ST_DRAIN);

endmodule

// File: tb/tb_pixel_color_sched.sv
// Purpose : self-checking bench for pixel_color_sched with a one-cycle colormap model.
// Latency : bench drives at posedge+1, compares every cycle at negedge.
// Backpr. : out_ready and req_valid patterns are directed per scenario.
`timescale 1ns/1ps
module tb_pixel_color_sched;
  localparam int N_REQ = 4, ITER_W = 16, ADDR_W = 17, FIFO_DEPTH = 4, CM_LAT = 1, DEF_MAX_ITER = 256;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_valid, req_ready;
  logic [N_REQ*ITER_W-1:0] req_iter;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [ITER_W-1:0]       cm_iter_count, cm_max_iter;
  logic                    cm_valid_in;
  logic [15:0]             cm_rgb565;
  logic                    cm_valid_out;
  logic                    out_valid, out_ready;
  logic [15:0]             out_rgb565;
  logic [ADDR_W-1:0]       out_addr;
  logic [ITER_W-1:0]       cfg_max_iter;
  logic                    cfg_we, cfg_busy;

  always #5 clk = ~clk;

  pixel_color_sched #(
    .N_REQ(N_REQ), .ITER_W(ITER_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH),
    .CM_LAT(CM_LAT), .DEF_MAX_ITER(DEF_MAX_ITER)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_iter(req_iter), .req_addr(req_addr),
    .cm_iter_count(cm_iter_count), .cm_max_iter(cm_max_iter), .cm_valid_in(cm_valid_in),
    .cm_rgb565(cm_rgb565), .cm_valid_out(cm_valid_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_rgb565(out_rgb565), .out_addr(out_addr),
    .cfg_max_iter(cfg_max_iter), .cfg_we(cfg_we), .cfg_busy(cfg_busy)
  );

  // Colormap stand-in: fixed colour function, one-cycle latency.
  function automatic logic [15:0] cmap(input logic [15:0] it, input logic [15:0] mx);
    return (it >= mx) ? 16'h0000 : 16'(it * 3 + mx);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cm_valid_out <= 1'b0;
      cm_rgb565    <= '0;
    end else begin
      cm_valid_out <= cm_valid_in;
      cm_rgb565    <= cmap(cm_iter_count, cm_max_iter);
    end
  end

  // Requester i presents its pixel number pc[i]; it advances after each accept.
  int pc [N_REQ];

  task automatic drive_pix();
    for (int i = 0; i < N_REQ; i++) begin
      req_iter[i*ITER_W +: ITER_W] = 16'((i * 37 + pc[i] * 45) % 300);
      req_addr[i*ADDR_W +: ADDR_W] = 17'(i * 1000 + pc[i]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    drive_pix();
  end

  // Bookkeeping
  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: queues of coloured pixels, no knowledge of DUT internals.
  typedef struct {
    logic [15:0]       rgb;
    logic [ADDR_W-1:0] addr;
    int                due;
  } pix_t;

  pix_t m_fifo[$];
  pix_t m_pipe[$];
  int   m_ptr = 0, m_max = DEF_MAX_ITER, m_pend = DEF_MAX_ITER, cyc = 0;
  bit   m_drain = 0;

  int                gnt_log[$];
  int                mx_log[$];
  logic [ADDR_W-1:0] out_log[$];
  int busy_cnt = 0, busy_eps = 0, ov_cnt = 0, first_gnt = -1, first_ov = -1;
  bit busy_prev = 0;

  always @(negedge clk) begin
    int   g, infl;
    pix_t p;
    logic [N_REQ-1:0]  e_rdy;
    logic [ITER_W-1:0] g_iter;
    cyc++;
    if (!rst_n) begin
      m_fifo.delete(); m_pipe.delete();
      m_ptr = 0; m_drain = 0; m_max = DEF_MAX_ITER; m_pend = DEF_MAX_ITER;
      busy_prev = 0;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_cm_valid_in", 32'(cm_valid_in), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_cfg_busy", 32'(cfg_busy), 0);
    end else begin
      infl = m_pipe.size();
      chk("out_valid", 32'(out_valid), 32'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) begin
        chk("out_rgb565", 32'(out_rgb565), 32'(m_fifo[0].rgb));
        chk("out_addr", 32'(out_addr), 32'(m_fifo[0].addr));
      end
      chk("cfg_busy", 32'(cfg_busy), 32'(m_drain));

      g = -1;
      if (!m_drain && (m_fifo.size() + infl < FIFO_DEPTH))
        for (int k = 0; k < N_REQ; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
      e_rdy  = (g >= 0) ? N_REQ'(1 << g) : '0;
      g_iter = (g >= 0) ? req_iter[g*ITER_W +: ITER_W] : '0;
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("cm_valid_in", 32'(cm_valid_in), 32'(g >= 0));
      chk("cm_iter_count", 32'(cm_iter_count), 32'(g_iter));
      if (g >= 0) chk("cm_max_iter", 32'(cm_max_iter), 32'(m_max));

      // Observations used by the scenario-level literal checks.
      for (int i = 0; i < N_REQ; i++)
        if (req_valid[i] && req_ready[i]) begin
          gnt_log.push_back(i);
          pc[i]++;
        end
      if (cm_valid_in) mx_log.push_back(int'(cm_max_iter));
      if (cm_valid_in && first_gnt < 0) first_gnt = cyc;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (out_valid) ov_cnt++;
      if (out_valid && out_ready) out_log.push_back(out_addr);
      if (cfg_busy) begin
        busy_cnt++;
        if (!busy_prev) busy_eps++;
      end
      busy_prev = cfg_busy;

      // Advance the model by one clock.
      if (m_fifo.size() != 0 && out_ready) void'(m_fifo.pop_front());
      while (m_pipe.size() != 0 && m_pipe[0].due == cyc) begin
        p = m_pipe.pop_front();
        m_fifo.push_back(p);
      end
      if (g >= 0) begin
        p.rgb  = cmap(g_iter, 16'(m_max));
        p.addr = req_addr[g*ADDR_W +: ADDR_W];
        p.due  = cyc + CM_LAT;
        m_pipe.push_back(p);
        m_ptr = (g + 1) % N_REQ;
      end
      if (!m_drain) begin
        if (cfg_we) begin m_drain = 1; m_pend = int'(cfg_max_iter); end
      end else if (cfg_we) begin
        m_pend = int'(cfg_max_iter);
      end else if (infl == 0) begin
        m_drain = 0;
        m_max   = m_pend;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; out_ready = 1'b0; cfg_we = 1'b0; cfg_max_iter = '0;
    for (int i = 0; i < N_REQ; i++) pc[i] = 0;
    drive_pix();
    req_valid = '1;                       // ready must stay low while in reset
    repeat (3) tick();
    chk("lit_reset_req_ready", 32'(req_ready), 0);
    chk("lit_reset_out_valid", 32'(out_valid), 0);
    req_valid = '0;
    rst_n = 1'b1;

    // All requesters streaming, sink always ready.
    gnt_log.delete(); out_log.delete(); ov_cnt = 0; first_gnt = -1; first_ov = -1;
    req_valid = '1; out_ready = 1'b1;
    repeat (16) tick();
    req_valid = '0;
    repeat (4) tick();
    chk("lit_stream_grants", gnt_log.size(), 16);
    chk("lit_stream_grant0", gnt_log[0], 0);
    chk("lit_stream_grant1", gnt_log[1], 1);
    chk("lit_stream_grant2", gnt_log[2], 2);
    chk("lit_stream_grant3", gnt_log[3], 3);
    chk("lit_stream_grant4", gnt_log[4], 0);
    chk("lit_stream_startup", first_ov - first_gnt, 2);
    chk("lit_stream_outs", ov_cnt, 16);
    chk("lit_stream_addr0", 32'(out_log[0]), 0);
    chk("lit_stream_addr1", 32'(out_log[1]), 1000);
    chk("lit_stream_addr3", 32'(out_log[3]), 3000);
    chk("lit_stream_addr4", 32'(out_log[4]), 1);

    // Sink stalled: credit limits to FIFO_DEPTH grants.
    gnt_log.delete();
    out_ready = 1'b0; req_valid = 4'b0001;
    repeat (10) tick();
    chk("lit_stall_grants", gnt_log.size(), 4);
    chk("lit_stall_out_valid", 32'(out_valid), 1);
    chk("lit_stall_req_ready", 32'(req_ready), 0);
    gnt_log.delete();
    out_ready = 1'b1;
    tick();
    chk("lit_resume_same_cycle", gnt_log.size(), 0);
    tick();
    chk("lit_resume_next_cycle", gnt_log.size(), 1);
    req_valid = '0;
    repeat (8) tick();

    // max_iter change mid-stream.
    mx_log.delete(); busy_cnt = 0; busy_eps = 0;
    req_valid = '1;
    repeat (5) tick();
    cfg_max_iter = 16'd1000; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    repeat (8) tick();
    req_valid = '0;
    repeat (4) tick();
    chk("lit_cfg_busy_cycles", busy_cnt, 2);
    chk("lit_cfg_old_max", mx_log[5], 256);
    chk("lit_cfg_new_max", mx_log[6], 1000);

    // Round-robin wrap with a single requester.
    gnt_log.delete();
    req_valid = 4'b0100;
    repeat (2) tick();
    req_valid = 4'b1101;
    tick();
    req_valid = '0;
    repeat (4) tick();
    chk("lit_rr_g0", gnt_log[0], 2);
    chk("lit_rr_g1", gnt_log[1], 2);
    chk("lit_rr_g2", gnt_log[2], 3);

    // Back-to-back config writes collapse into one drain.
    mx_log.delete(); busy_cnt = 0; busy_eps = 0;
    cfg_max_iter = 16'd500; cfg_we = 1'b1;
    tick();
    cfg_max_iter = 16'd700;
    tick();
    cfg_we = 1'b0;
    repeat (3) tick();
    req_valid = 4'b0001;
    repeat (3) tick();
    req_valid = '0;
    repeat (4) tick();
    chk("lit_cfg2_episodes", busy_eps, 1);
    chk("lit_cfg2_busy_cycles", busy_cnt, 2);
    chk("lit_cfg2_max", mx_log[0], 700);

    // Reset with 3 pixels queued and 1 lookup in flight.
    out_ready = 1'b0; req_valid = 4'b0001;
    repeat (4) tick();
    chk("lit_prerst_out_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_out_valid", 32'(out_valid), 0);
    chk("lit_rst_req_ready", 32'(req_ready), 0);
    req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1; out_ready = 1'b1; ov_cnt = 0;
    repeat (6) tick();
    chk("lit_postrst_no_stale", ov_cnt, 0);

    // Final stream after reset.
    req_valid = '1;
    repeat (8) tick();
    req_valid = '0;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pixel_color_sched.md
PIXEL_COLOR_SCHED -- requirements
Module: pixel_color_sched

Interface
REQ-001 Parameters SHALL be:
- N_REQ, 4, number of pixel-result requesters (2..8).
- ITER_W, 16, iteration count width.
- ADDR_W, 17, framebuffer pixel address width.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >=2).
- CM_LAT, 1, colormap latency in cycles.
- DEF_MAX_ITER, 256, max_iter value after reset.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock; every register is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  N_REQ  per-requester result valid.
- req_ready  out  N_REQ  per-requester accept.
- req_iter  in  N_REQ*ITER_W  packed iteration counts; requester i occupies [i*ITER_W +: ITER_W].
- req_addr  in  N_REQ*ADDR_W  packed pixel addresses, packed the same way.
- cm_iter_count  out  ITER_W  to colormap.
- cm_max_iter  out  ITER_W  to colormap.
- cm_valid_in  out  1  to colormap.
- cm_rgb565  in  16  from colormap.
- cm_valid_out  in  1  from colormap.
- out_valid  out  1  colored pixel valid.
- out_ready  in  1  downstream accept.
- out_rgb565  out  16  pixel color.
- out_addr  out  ADDR_W  pixel address.
- cfg_max_iter  in  ITER_W  new max_iter value.
- cfg_we  in  1  one-cycle config write strobe.
- cfg_busy  out  1  config update pending.

Function
REQ-003 Request transfer SHALL occur on cycles where req_valid[i] and req_ready[i] are both 1; at most one req_ready bit SHALL be 1 per cycle.
REQ-004 req_ready SHALL be combinational from req_valid, the round-robin pointer, state and credit; it SHALL NOT depend on out_ready.
REQ-005 Round-robin arbitration SHALL grant the first valid requester at or after pointer rr_ptr, searching upward modulo N_REQ.
REQ-006 After a grant to requester g, rr_ptr SHALL become (g+1) mod N_REQ; with no grant, rr_ptr SHALL hold.
REQ-007 On a grant, in the same cycle:
- cm_valid_in=1;
- cm_iter_count = granted req_iter;
- cm_max_iter = active max_iter register.
Otherwise cm_valid_in=0 and cm_iter_count=0.
REQ-008 The granted req_addr SHALL be delayed CM_LAT cycles in a shift register aligned with cm_valid_out.
REQ-009 When cm_valid_out=1, {cm_rgb565, delayed addr} SHALL be pushed into the output FIFO; the colormap has no backpressure, so the push can never be refused.
REQ-010 Credit rule: a grant SHALL be issued only if fifo_count + inflight < FIFO_DEPTH.
- inflight = number of lookups issued but not yet returned (0..CM_LAT).
- Under this rule FIFO overflow SHALL be impossible.
REQ-011 out_valid SHALL equal FIFO non-empty; out_rgb565/out_addr SHALL present the head entry; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-012 A push and a pop in the same cycle SHALL leave fifo_count unchanged, including when the FIFO is full or empty-then-pushed.
REQ-013 Read and write FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-014 The FSM SHALL have states RUN and DRAIN.
- RUN with cfg_we=1 -> DRAIN; pend_max_iter <= cfg_max_iter.
- In DRAIN no grants are issued (req_ready=0).
- cfg_we in DRAIN overwrites pend_max_iter and stays in DRAIN.
- DRAIN with inflight==0 and cfg_we=0 -> RUN; max_iter <= pend_max_iter on that edge.
REQ-015 cfg_busy SHALL be 1 exactly while state is DRAIN.
REQ-016 The FIFO SHALL continue to drain to out_* during DRAIN; the config change SHALL NOT wait for the FIFO to empty.
REQ-017 Pixels issued before the cfg_we cycle SHALL use the old max_iter; pixels issued after the return to RUN SHALL use the new value.
REQ-018 Order SHALL be preserved: out_* order equals grant order.

Reset
REQ-019 While rst_n=0, the following SHALL be forced:
- state=RUN, rr_ptr=0, inflight=0, fifo_count=0;
- FIFO pointers=0, max_iter=pend_max_iter=DEF_MAX_ITER;
- req_ready=0, cm_valid_in=0, out_valid=0, cfg_busy=0, delay line cleared.
REQ-020 Reset asserted mid-operation SHALL discard all in-flight and FIFO-held pixels; no output SHALL appear from them after reset release.
REQ-021 First grant possible on the first rising edge after rst_n deasserts.

Verification
REQ-022 All 4 req_valid held at 1, out_ready=1 -> grants in order 0,1,2,3,0,...; one out_valid per cycle after 2-cycle startup; addresses in order.
REQ-023 out_ready=0, req 0 continuously valid -> exactly 4 grants, then req_ready=0; out_valid=1 with fifo full; after out_ready=1, a grant resumes in the cycle fifo_count+inflight<4.
REQ-024 cfg_we with cfg_max_iter=1000 during streaming:
- req_ready=0 and cfg_busy=1 for the drain cycle(s);
- the next issued lookup shows cm_max_iter=1000; earlier ones show 256.
REQ-025 Only req 2 valid, rr_ptr=3 -> req 2 granted; rr_ptr becomes 3.
REQ-026 Assert rst_n=0 with 3 pixels in the FIFO and 1 in flight -> out_valid=0 immediately; no stale pixel output after release.
REQ-027 Two cfg_we pulses (500 then 700) one cycle apart -> max_iter ends at 700; single DRAIN episode.
